// File: rtl/skid_pipe_register.sv
// -----------------------------------------------------------------------------
// skid_pipe_register
//
// Pipeline stage register with a valid/ready handshake on both sides. It is a
// drop-in replacement for a load-enabled register at a pipeline stage boundary
// where the downstream stage can apply back-pressure.
//
// A one-entry skid buffer lets in_ready come straight from a flop and still
// sustain one transfer per cycle. After downstream stalls, at most one extra
// word is absorbed into the skid register.
//
// Optional feature macro: SKID_PIPE_REGISTER_FLUSH_EN
//   defined   : flush squashes all held entries. Both valid bits clear, the
//               data registers keep their contents, and any input transfer in
//               that cycle is dropped.
//   undefined : the flush port is present but ignored. No flush logic exists.
//
// Parameters
//   WIDTH       payload width in bits (>= 1)
//   RESET_VALUE value of out_data and the skid data register after reset
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   flush      synchronous squash of held entries (see macro above)
//   in_valid   upstream presents in_data
//   in_ready   stage can accept data (registered)
//   in_data    upstream payload
//   out_valid  out_data is valid (registered)
//   out_ready  downstream accepts out_data
//   out_data   payload, driven directly from the main register
//   occupancy  number of held entries, 0..2 (registered)
// -----------------------------------------------------------------------------
module skid_pipe_register #(
  parameter int unsigned            WIDTH       = 32,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // EMPTY: nothing held. ONE: main register holds a word.
  // FULL: both main and skid registers hold words.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] main_data_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;
  logic [1:0]       occupancy_reg;

  // Data-path steering decided alongside the next state.
  logic load_main_from_in;
  logic load_main_from_skid;
  logic load_skid;

  logic flush_active;

`ifdef SKID_PIPE_REGISTER_FLUSH_EN
  assign flush_active = flush;
`else
  // The port stays in the interface so both builds are pin-compatible.
  // It is tied off here and has no effect.
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_active = 1'b0;
`endif

  // Next-state and load decisions. The handshakes use the registered
  // in_ready/out_valid. In EMPTY, in_ready is 1, so in_valid alone is an
  // input transfer. In FULL, in_ready is 0, so in_valid is ignored.
  always_comb begin
    state_next          = state_reg;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    unique case (state_reg)
      ST_EMPTY: begin
        if (in_valid) begin
          load_main_from_in = 1'b1;
          state_next        = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_valid && out_ready) begin
          // Pop and push in the same cycle: occupancy stays at one.
          load_main_from_in = 1'b1;
        end else if (in_valid) begin
          load_skid  = 1'b1;
          state_next = ST_FULL;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          // The skid word moves up behind the popped word. This keeps
          // FIFO order.
          load_main_from_skid = 1'b1;
          state_next          = ST_ONE;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase

    // A flush overrides every transition. Any input transfer in this cycle
    // is discarded, and the data registers keep what they hold.
    if (flush_active) begin
      state_next          = ST_EMPTY;
      load_main_from_in   = 1'b0;
      load_main_from_skid = 1'b0;
      load_skid           = 1'b0;
    end
  end

  // The state register and the registered outputs. The outputs are decoded
  // from state_next, so each one is a flop with no input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_EMPTY;
      main_data_reg <= RESET_VALUE;
      skid_data_reg <= RESET_VALUE;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      occupancy_reg <= 2'd0;
    end else begin
      state_reg <= state_next;

      if (load_main_from_in) begin
        main_data_reg <= in_data;
      end else if (load_main_from_skid) begin
        main_data_reg <= skid_data_reg;
      end

      if (load_skid) begin
        skid_data_reg <= in_data;
      end

      unique case (state_next)
        ST_ONE: begin
          out_valid_reg <= 1'b1;
          in_ready_reg  <= 1'b1;
          occupancy_reg <= 2'd1;
        end
        ST_FULL: begin
          out_valid_reg <= 1'b1;
          in_ready_reg  <= 1'b0;
          occupancy_reg <= 2'd2;
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          occupancy_reg <= 2'd0;
        end
      endcase
    end
  end

  assign out_data  = main_data_reg;
  assign out_valid = out_valid_reg;
  assign in_ready  = in_ready_reg;
  assign occupancy = occupancy_reg;

endmodule

// File: tb/tb_skid_pipe_register.sv
// -----------------------------------------------------------------------------
// tb_skid_pipe_register
//
// Directed testbench for skid_pipe_register (WIDTH=32, RESET_VALUE=0).
//
// Coverage:
//   - reset
//   - streaming
//   - stall and skid
//   - FULL ignoring input
//   - flush
//   - reset mid-stream
//
// Expected flush behaviour follows SKID_PIPE_REGISTER_FLUSH_EN. Build the bench
// with the same macro setting as the design.
//
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point.
// -----------------------------------------------------------------------------
module tb_skid_pipe_register;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  skid_pipe_register #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic exp_ov, input logic exp_ir,
                             input logic [1:0] exp_occ, input logic [31:0] exp_od);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    check({tag, ".in_ready"},  32'(in_ready),  32'(exp_ir));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(exp_occ));
    check({tag, ".out_data"},  out_data,       exp_od);
    $display("step %-12s ov=%0b ir=%0b occ=%0d od=0x%0h", tag, out_valid, in_ready, occupancy, out_data);
  endtask

  initial begin
    // Reset: held low for 2 cycles while upstream pushes garbage.
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    tick(); check_state("reset0", 1'b0, 1'b1, 2'd0, 32'h0);
    tick(); check_state("reset1", 1'b0, 1'b1, 2'd0, 32'h0);

    // Streaming with out_ready=1: each word shows one edge later, occupancy 1.
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
    tick(); check_state("stream1", 1'b1, 1'b1, 2'd1, 32'h1);
    in_data = 32'h2;
    tick(); check_state("stream2", 1'b1, 1'b1, 2'd1, 32'h2);
    in_data = 32'h3;
    tick(); check_state("stream3", 1'b1, 1'b1, 2'd1, 32'h3);
    in_valid = 1'b0;
    tick(); check_state("drain", 1'b0, 1'b1, 2'd0, 32'h3);

    // Stall and skid.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick(); check_state("pushA", 1'b1, 1'b1, 2'd1, 32'hA);
    in_data = 32'hB;
    tick(); check_state("pushB_full", 1'b1, 1'b0, 2'd2, 32'hA);

    // FULL ignores input for 3 cycles.
    in_data = 32'hC;
    tick(); check_state("ignC0", 1'b1, 1'b0, 2'd2, 32'hA);
    tick(); check_state("ignC1", 1'b1, 1'b0, 2'd2, 32'hA);
    tick(); check_state("ignC2", 1'b1, 1'b0, 2'd2, 32'hA);

    // Release: A pops, B moves up, and in_ready returns to 1.
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); check_state("popA", 1'b1, 1'b1, 2'd1, 32'hB);
    tick(); check_state("popB", 1'b0, 1'b1, 2'd0, 32'hB);

    // Flush while FULL, with a concurrent push of 0xF.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h10;
    tick(); check_state("fl_push10", 1'b1, 1'b1, 2'd1, 32'h10);
    in_data = 32'h11;
    tick(); check_state("fl_full", 1'b1, 1'b0, 2'd2, 32'h10);
    flush = 1'b1; in_data = 32'hF;
    tick();
`ifdef SKID_PIPE_REGISTER_FLUSH_EN
    check_state("flush", 1'b0, 1'b1, 2'd0, 32'h10);
`else
    check_state("flush_off", 1'b1, 1'b0, 2'd2, 32'h10);
`endif
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
`ifdef SKID_PIPE_REGISTER_FLUSH_EN
    check_state("post_fl0", 1'b0, 1'b1, 2'd0, 32'h10);
`else
    check_state("post_fl0", 1'b1, 1'b1, 2'd1, 32'h11);
`endif
    tick();
`ifdef SKID_PIPE_REGISTER_FLUSH_EN
    check_state("post_fl1", 1'b0, 1'b1, 2'd0, 32'h10);
`else
    check_state("post_fl1", 1'b0, 1'b1, 2'd0, 32'h11);
`endif

    // Reset mid-stream from FULL, then a normal push.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h20;
    tick(); check_state("rs_push20", 1'b1, 1'b1, 2'd1, 32'h20);
    in_data = 32'h21;
    tick(); check_state("rs_full", 1'b1, 1'b0, 2'd2, 32'h20);
    rst = 1'b0; in_data = 32'h22; out_ready = 1'b1;
    tick(); check_state("rs_reset", 1'b0, 1'b1, 2'd0, 32'h0);
    rst = 1'b1; in_data = 32'h30; out_ready = 1'b0;
    tick(); check_state("rs_push30", 1'b1, 1'b1, 2'd1, 32'h30);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); check_state("rs_pop30", 1'b0, 1'b1, 2'd0, 32'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skid_pipe_register.md
# skid_pipe_register

Parametrised pipeline register that replaces the plain load-enabled N-bit register at pipeline stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) where back-pressure is needed. It carries a WIDTH-bit payload with a valid/ready handshake on both sides. A one-entry skid buffer keeps full throughput with a registered `in_ready`, and an optional flush squashes in-flight data on branch or jump redirects.

## Interface
- `WIDTH`, default 32: payload width in bits, 1 or more.
- `RESET_VALUE`, default 0: value of `out_data` and the internal data registers after reset.
- `clk` input, 1 bit: clock, rising-edge.
- `rst` input, 1 bit: reset, synchronous, active-low. Sampled on the rising edge of `clk`.
- `flush` input, 1 bit: synchronous squash of all held entries (see Configuration).
- `in_valid` input, 1 bit: upstream presents `in_data`.
- `in_ready` output, 1 bit: stage can accept data. Driven directly from a register.
- `in_data` input, WIDTH bits: upstream payload.
- `out_valid` output, 1 bit: `out_data` is valid.
- `out_ready` input, 1 bit: downstream accepts `out_data`.
- `out_data` output, WIDTH bits: payload, driven directly from the main register.
- `occupancy` output, 2 bits: number of held entries, 0 to 2.

## Operation
- Storage is a main register (drives `out_data`) plus a skid register. Each has its own valid bit.
- An input transfer occurs when `in_valid` and `in_ready` are both high. An output transfer occurs when `out_valid` and `out_ready` are both high.
- The state machine is derived from the two valid bits:
  - EMPTY: `out_valid`=0, `in_ready`=1, `occupancy`=0.
  - ONE: `out_valid`=1, `in_ready`=1, `occupancy`=1.
  - FULL: `out_valid`=1, `in_ready`=0, `occupancy`=2.
- Transitions, with `fl` meaning `flush` is active:
  - EMPTY, `in_valid`: main <= `in_data`, go to ONE. Otherwise stay in EMPTY.
  - ONE, `in_valid` and `out_ready`: main <= `in_data`, stay in ONE.
  - ONE, `in_valid` and not `out_ready`: skid <= `in_data`, go to FULL.
  - ONE, not `in_valid` and `out_ready`: go to EMPTY.
  - ONE, neither: hold.
  - FULL, `out_ready`: main <= skid, go to ONE. `in_valid` is ignored because `in_ready` is 0.
  - FULL, not `out_ready`: hold.
  - Any state with `fl`: go to EMPTY next cycle. Valid bits clear, data registers keep their contents, and any input transfer in that cycle is discarded.
- Ordering is strict FIFO: skid data always leaves after main data.
- Data registers load only on the transitions above and otherwise hold their value.
- While `out_valid`=0, `out_data` shows the last value held, or RESET_VALUE after reset.

## Timing
- Reset (`rst`=0 at a rising edge): state EMPTY. `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=RESET_VALUE, skid data=RESET_VALUE.
- Reset has priority over flush and over all handshakes.
- Reset asserted mid-operation drops all held entries at that edge with no partial transfer.
- Latency: data accepted at edge k appears on `out_data` with `out_valid`=1 after edge k, so it can be consumed at edge k+1.
- Throughput: one transfer per cycle in steady state while `out_ready`=1.
- `in_ready` falls the cycle after the skid fills, never combinationally. At most one extra word (held in the skid) is absorbed after downstream stalls.
- Simultaneous input and output transfer in ONE keeps occupancy constant.
- No combinational path exists from any input to any output.

## Configuration
- Macro `SKID_PIPE_REGISTER_FLUSH_EN`.
- Defined: `flush` behaves as described in Operation.
- Undefined: the `flush` port remains in the interface, but it is ignored and no flush logic is synthesised.

## Test plan
- Reset: drive `rst`=0 for 2 cycles with `in_valid`=1 and `in_data`=0xDEADBEEF. Required: `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=RESET_VALUE (0) throughout.
- Streaming: `out_ready`=1, push 0x1, 0x2, 0x3 on consecutive cycles. Required: the same values appear on `out_data` one cycle later each, and `occupancy` stays at 1.
- Stall and skid: push 0xA, 0xB with `out_ready`=0. Required: `occupancy`=2 and `in_ready`=0 the next cycle. Then raise `out_ready`: required output is 0xA then 0xB, and `in_ready` returns to 1 after the first pop.
- FULL ignores input: in FULL, hold `in_valid`=1 with `in_data`=0xC for 3 cycles while `out_ready`=0. Required: 0xC is never accepted and `occupancy` stays at 2.
- Flush (macro defined): reach FULL, then assert `flush` together with `in_valid`=1 and `in_data`=0xF. Required next cycle: `out_valid`=0, `occupancy`=0, 0xF dropped. With the macro undefined, the same stimulus leaves the state unchanged.
- Reset mid-stream: reach FULL, then pull `rst` low for 1 cycle. Required next cycle: EMPTY and `out_data`=RESET_VALUE; the next push works normally.
